// File: rtl/register_toggle_multi_pkg.sv
// Shared op-code encoding for the multi-channel bit-operation register.
// Imported by the interface, the per-channel lane and the top level.
package register_toggle_multi_pkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    OP_HOLD    = 3'd0,
    OP_LOAD    = 3'd1,
    OP_SET     = 3'd2,
    OP_CLRBITS = 3'd3,
    OP_TOGGLE  = 3'd4,
    OP_INVERT  = 3'd5,
    OP_RESTORE = 3'd6,
    OP_RSVD    = 3'd7
  } op_t;

endpackage

// File: rtl/register_toggle_multi_if.sv
// Bus bundle for register_toggle_multi: per-channel ops and operands in,
// channel words and event flags out.
interface register_toggle_multi_if
  import register_toggle_multi_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CHANNELS     = 4,
  parameter int PERIOD_WIDTH = 16
);

  logic                           clock_enable;
  logic                           clear;
  logic [OP_WIDTH*CHANNELS-1:0]   op;
  logic [WORD_WIDTH*CHANNELS-1:0] data_in;
  logic [CHANNELS-1:0]            auto_enable;
  logic [PERIOD_WIDTH-1:0]        auto_period;
  logic [WORD_WIDTH*CHANNELS-1:0] data_out;
  logic [CHANNELS-1:0]            changed;
  logic [CHANNELS-1:0]            auto_tick;

  modport master (
    output clock_enable, clear, op, data_in, auto_enable, auto_period,
    input  data_out, changed, auto_tick
  );

  modport slave (
    input  clock_enable, clear, op, data_in, auto_enable, auto_period,
    output data_out, changed, auto_tick
  );

endinterface

// File: rtl/register.sv
// Plain word register with load enable and asynchronous active-high reset.
module register #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      q <= RESET_VALUE;
    else if (enable)
      q <= d;
  end

endmodule

// File: rtl/register_toggle_multi_lane.sv
// One channel: next-value mux, auto-toggle timer and change/tick flags.
// The word itself lives in a `register` instance.
module register_toggle_multi_lane
  import register_toggle_multi_pkg::*;
#(
  parameter int                    WORD_WIDTH   = 8,
  parameter int                    PERIOD_WIDTH = 16,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clock_enable,
  input  logic                    clear,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    auto_enable,
  input  logic [PERIOD_WIDTH-1:0] period_last,
  output logic [WORD_WIDTH-1:0]   data_out,
  output logic                    changed,
  output logic                    auto_tick
);

  logic [WORD_WIDTH-1:0]   q;
  logic [WORD_WIDTH-1:0]   next_q;
  logic [PERIOD_WIDTH-1:0] count;
  logic [PERIOD_WIDTH-1:0] next_count;
  logic                    fire;

  // >= rather than == so a period lowered below the running count fires at once
  assign fire = auto_enable && (count >= period_last);

  always_comb begin
    next_q = q;
    if (clear) begin
      next_q = RESET_VALUE;
    end else begin
      case (op_t'(op))
        OP_LOAD:    next_q = data_in;
        OP_SET:     next_q = q | data_in;
        OP_CLRBITS: next_q = q & ~data_in;
        OP_TOGGLE:  next_q = q ^ data_in;
        OP_INVERT:  next_q = ~q;
        OP_RESTORE: next_q = RESET_VALUE;
        // HOLD and reserved: only here may a timer fire invert the word
        default:    next_q = fire ? ~q : q;
      endcase
    end
  end

  always_comb begin
    next_count = count + 1'b1;
    if (clear || !auto_enable || fire)
      next_count = '0;
  end

  register #(
    .WIDTH       (WORD_WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_word (
    .clock  (clock),
    .reset  (reset),
    .enable (clock_enable),
    .d      (next_q),
    .q      (q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count     <= '0;
      changed   <= 1'b0;
      auto_tick <= 1'b0;
    end else if (clock_enable) begin
      count     <= next_count;
      changed   <= (next_q != q);
      auto_tick <= fire && !clear;
    end
  end

  assign data_out = q;

endmodule

// File: rtl/register_toggle_multi.sv
// Multi-channel bit-operation register with per-channel auto-toggle timers.
// Channels are independent lanes sharing only the clamped timer period.
module register_toggle_multi
  import register_toggle_multi_pkg::*;
#(
  parameter int                    WORD_WIDTH   = 8,
  parameter int                    CHANNELS     = 4,
  parameter logic [WORD_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int                    PERIOD_WIDTH = 16
) (
  input logic                  clock,
  input logic                  reset,
  register_toggle_multi_if.slave bus
);

  logic [PERIOD_WIDTH-1:0] period_last;

  // eff_period = max(auto_period, 1); lanes compare against eff_period-1
  assign period_last = (bus.auto_period == '0) ? '0 : bus.auto_period - 1'b1;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    register_toggle_multi_lane #(
      .WORD_WIDTH   (WORD_WIDTH),
      .PERIOD_WIDTH (PERIOD_WIDTH),
      .RESET_VALUE  (RESET_VALUE)
    ) u_lane (
      .clock        (clock),
      .reset        (reset),
      .clock_enable (bus.clock_enable),
      .clear        (bus.clear),
      .op           (bus.op[OP_WIDTH*k +: OP_WIDTH]),
      .data_in      (bus.data_in[WORD_WIDTH*k +: WORD_WIDTH]),
      .auto_enable  (bus.auto_enable[k]),
      .period_last  (period_last),
      .data_out     (bus.data_out[WORD_WIDTH*k +: WORD_WIDTH]),
      .changed      (bus.changed[k]),
      .auto_tick    (bus.auto_tick[k])
    );
  end

endmodule

// File: tb/tb_register_toggle_multi.sv
// Self-checking bench for register_toggle_multi: op table, timer sequences,
// gating/clear, async reset and random traffic against a scoreboarded model.
module tb_register_toggle_multi;
  import register_toggle_multi_pkg::*;

  localparam int              W  = 8;
  localparam int              CH = 4;
  localparam int              PW = 16;
  localparam logic [W-1:0]    RV = 8'hA5;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  register_toggle_multi_if #(.WORD_WIDTH(W), .CHANNELS(CH), .PERIOD_WIDTH(PW)) bus ();

  register_toggle_multi #(
    .WORD_WIDTH(W), .CHANNELS(CH), .RESET_VALUE(RV), .PERIOD_WIDTH(PW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [W*CH-1:0] q;
    logic [CH-1:0]   chg;
    logic [CH-1:0]   tick;
  } exp_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         chg;
  } vec_t;

  exp_t          sb[$];
  logic [W-1:0]  mq[CH];
  logic [PW-1:0] mcnt[CH];
  logic [CH-1:0] mchg, mtick;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      mq[k]   = RV;
      mcnt[k] = '0;
    end
    mchg  = '0;
    mtick = '0;
    sb.delete();
  endtask

  // Reference behaviour for one clock edge, using the inputs currently driven
  task automatic model_step();
    exp_t          e;
    logic [PW-1:0] last;
    logic [W-1:0]  nq, d;
    logic          fire;
    if (bus.clock_enable) begin
      last = bus.auto_period;
      if (last != 0) last = last - 1;
      for (int k = 0; k < CH; k++) begin
        d    = bus.data_in[k*W +: W];
        fire = bus.auto_enable[k] && (mcnt[k] >= last);
        if (bus.clear) begin
          nq       = RV;
          mcnt[k]  = '0;
          mtick[k] = 1'b0;
        end else begin
          case (int'(bus.op[3*k +: 3]))
            1:       nq = d;
            2:       nq = mq[k] | d;
            3:       nq = mq[k] & ~d;
            4:       nq = mq[k] ^ d;
            5:       nq = ~mq[k];
            6:       nq = RV;
            default: nq = fire ? ~mq[k] : mq[k];
          endcase
          if (!bus.auto_enable[k] || fire) mcnt[k] = '0;
          else                             mcnt[k] = mcnt[k] + 1;
          mtick[k] = fire;
        end
        mchg[k] = (nq != mq[k]);
        mq[k]   = nq;
      end
    end
    for (int k = 0; k < CH; k++) e.q[k*W +: W] = mq[k];
    e.chg  = mchg;
    e.tick = mtick;
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      check("sb_data_out", 64'(bus.data_out), 64'(e.q));
      check("sb_changed",  64'(bus.changed),  64'(e.chg));
      check("sb_auto_tick", 64'(bus.auto_tick), 64'(e.tick));
    end
  endtask

  task automatic set_op(input int ch, input logic [2:0] op, input logic [W-1:0] d);
    bus.op[3*ch +: 3]    = op;
    bus.data_in[ch*W +: W] = d;
  endtask

  task automatic idle();
    bus.op      = '0;
    bus.data_in = '0;
  endtask

  vec_t         tbl[9];
  logic [W*CH-1:0] saved;

  initial begin
    tbl[0] = '{OP_LOAD,    8'h3C, 8'h3C, 1'b1};
    tbl[1] = '{OP_SET,     8'h3C, 8'h3F, 1'b1};
    tbl[2] = '{OP_CLRBITS, 8'h3C, 8'h03, 1'b1};
    tbl[3] = '{OP_TOGGLE,  8'h3C, 8'h33, 1'b1};
    tbl[4] = '{OP_INVERT,  8'h3C, 8'hF0, 1'b1};
    tbl[5] = '{OP_RESTORE, 8'h3C, 8'hA5, 1'b1};
    tbl[6] = '{OP_RSVD,    8'h3C, 8'h0F, 1'b0};
    tbl[7] = '{OP_HOLD,    8'h3C, 8'h0F, 1'b0};
    tbl[8] = '{OP_LOAD,    8'h0F, 8'h0F, 1'b0};

    reset            = 1'b1;
    bus.clock_enable = 1'b1;
    bus.clear        = 1'b0;
    bus.auto_enable  = '0;
    bus.auto_period  = '0;
    idle();
    model_reset();
    #12;
    check("reset_q",    64'(bus.data_out),  64'({CH{RV}}));
    check("reset_chg",  64'(bus.changed),   64'(0));
    check("reset_tick", 64'(bus.auto_tick), 64'(0));
    reset = 1'b0;

    // Op table on channel 0 starting from 0F
    for (int i = 0; i < 9; i++) begin
      set_op(0, OP_LOAD, 8'h0F);
      step();
      set_op(0, tbl[i].op, tbl[i].d);
      step();
      check("op_q",   64'(bus.data_out[W-1:0]), 64'(tbl[i].q));
      check("op_chg", 64'(bus.changed[0]),      64'(tbl[i].chg));
      idle();
    end

    // Auto toggle on channel 1, period 3
    set_op(1, OP_LOAD, 8'h00);
    step();
    idle();
    bus.auto_period = 16'd3;
    bus.auto_enable = 4'b0010;
    for (int i = 1; i <= 9; i++) begin
      step();
      check("auto_tick", 64'(bus.auto_tick[1]), 64'((i % 3) == 0));
      check("auto_q", 64'(bus.data_out[W +: W]), 64'((((i / 3) % 2) == 1) ? 8'hFF : 8'h00));
    end
    bus.auto_enable = 4'b0000;
    step();
    bus.auto_enable = 4'b0010;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("reenable_tick", 64'(bus.auto_tick[1]), 64'(i == 3));
    end
    check("reenable_q", 64'(bus.data_out[W +: W]), 64'(8'h00));

    // Collision: fire coincides with LOAD 55
    step();
    step();
    set_op(1, OP_LOAD, 8'h55);
    step();
    check("collide_q",    64'(bus.data_out[W +: W]), 64'(8'h55));
    check("collide_tick", 64'(bus.auto_tick[1]),     64'(1));
    idle();
    for (int i = 1; i <= 3; i++) begin
      step();
      check("post_collide_tick", 64'(bus.auto_tick[1]), 64'(i == 3));
    end
    check("post_collide_q", 64'(bus.data_out[W +: W]), 64'(8'hAA));

    // Gating: five frozen cycles with ops and timers active
    saved = bus.data_out;
    bus.auto_enable  = 4'b1111;
    bus.clock_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < CH; k++) set_op(k, 3'($urandom_range(1, 6)), 8'($urandom));
      step();
      check("gated_q", 64'(bus.data_out), 64'(saved));
    end
    bus.clock_enable = 1'b1;
    idle();
    bus.clear = 1'b1;
    set_op(2, OP_LOAD, 8'h11);
    step();
    check("clear_q",    64'(bus.data_out),  64'({CH{RV}}));
    check("clear_tick", 64'(bus.auto_tick), 64'(0));
    bus.clear = 1'b0;
    idle();
    for (int i = 1; i <= 3; i++) begin
      step();
      check("restart_tick", 64'(bus.auto_tick), 64'((i == 3) ? 4'b1111 : 4'b0000));
    end

    // Period 0 fires every enabled cycle
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.auto_period = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("p0_tick", 64'(bus.auto_tick), 64'(4'b1111));
    end

    // Lowering period 10 -> 2 at count 7
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    bus.auto_enable = 4'b1000;
    bus.auto_period = 16'd10;
    for (int i = 0; i < 7; i++) step();
    check("p10_no_tick", 64'(bus.auto_tick[3]), 64'(0));
    bus.auto_period = 16'd2;
    step();
    check("lowered_tick", 64'(bus.auto_tick[3]), 64'(1));

    // Asynchronous reset mid-cycle
    set_op(0, OP_LOAD, 8'h12);
    step();
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_q",    64'(bus.data_out),  64'({CH{RV}}));
    check("async_rst_chg",  64'(bus.changed),   64'(0));
    check("async_rst_tick", 64'(bus.auto_tick), 64'(0));
    model_reset();
    #2;
    reset = 1'b0;

    // Random traffic on all channels
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < CH; k++) set_op(k, 3'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 7) == 0) bus.auto_enable = 4'($urandom);
      bus.auto_period  = 16'($urandom_range(0, 5));
      bus.clear        = ($urandom_range(0, 19) == 0);
      bus.clock_enable = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
